ctrl_pipe_decoder: RTL and testbench
====================================

Name: ctrl_pipe_decoder

Overview:
- Parametrised successor to the single-cycle main decoder.
- Decodes the opcode in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Supports stall and flush, an optional extended opcode set (LUI/AUIPC/JALR), and a saturating illegal-instruction counter.
- Sits in the RISC-V pipeline controller, beside the hazard unit.

Parameters:
EXT_OPS, 1, 1 enables decode of LUI/AUIPC/JALR; 0 treats those opcodes as illegal
CNT_W, 8, width of the illegal-instruction counter
FLUSH_M, 0, 1 adds a flush_m input path that bubbles the EX/MEM register; 0 ties it inactive

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
op_d  in  7  opcode of the instruction in ID
valid_d  in  1  ID holds a real instruction; 0 decodes as a bubble
stall_e  in  1  hold the ID/EX register
flush_e  in  1  load a bubble into ID/EX (overrides stall_e)
flush_m  in  1  load a bubble into EX/MEM; ignored when FLUSH_M=0
imm_src_d  out  3  immediate type in ID, combinational (I=000 S=001 B=010 J=011 U=100)
illegal_d  out  1  combinational: valid_d and opcode not supported
reg_write_e, mem_write_e, branch_e, jump_e, jalr_e, alu_src_e, alu_a_src_e  out  1 each  EX control
result_src_e  out  2  EX result select (00 alu, 01 mem, 10 pc+4, 11 imm)
alu_op_e  out  2  EX ALU op class
reg_write_m, mem_write_m  out  1 each  MEM control
result_src_m  out  2  MEM result select
reg_write_w  out  1  WB control
result_src_w  out  2  WB result select
illegal_cnt  out  CNT_W  saturating count of illegal instructions that entered EX

Behaviour:
- Decode table, fields in order reg_write, imm_src, alu_src, alu_a_src, mem_write, result_src, branch, alu_op, jump, jalr:
  - LW 0000011: 1,000,1,0,0,01,0,00,0,0
  - SW 0100011: 0,001,1,0,1,00,0,00,0,0
  - R 0110011: 1,000,0,0,0,00,0,10,0,0
  - BEQ 1100011: 0,010,0,0,0,00,1,01,0,0
  - I-ALU 0010011: 1,000,1,0,0,00,0,10,0,0
  - JAL 1101111: 1,011,0,0,0,10,0,00,1,0
  - LUI 0110111 (EXT_OPS only): 1,100,1,0,0,11,0,00,0,0
  - AUIPC 0010111 (EXT_OPS only): 1,100,1,1,0,00,0,00,0,0
  - JALR 1100111 (EXT_OPS only): 1,000,1,0,0,10,0,00,1,1
- Unsupported opcode, or valid_d=0: all control fields 0, imm_src 000. illegal_d=1 only when valid_d=1.
- A bubble is the all-zero control bundle. Bubbles never write registers or memory.
- ID/EX register, priority order:
  - flush_e: load bubble, and clear the illegal tag.
  - else stall_e: hold.
  - else: load the decoded bundle and illegal_d as the tag.
- EX/MEM register loads every cycle. It loads a bubble when FLUSH_M=1 and flush_m=1. stall_e does not freeze EX/MEM; the hazard unit flushes EX on load-use.
- MEM/WB register loads every cycle with no flush.
- Latency: decoded op_d appears on *_e one cycle later, *_m two cycles later, *_w three cycles later.
- illegal_cnt increments by 1 on each rising edge where the ID/EX register loads with illegal tag 1 (not stalled, not flushed). It saturates at all-ones and never wraps.
- A stall cycle does not re-count: count on load, not on hold.
- Reset (rst_n=0, asynchronous): every registered output = 0 and illegal_cnt = 0, immediately and independent of clk. Combinational outputs still follow op_d.
- Release of rst_n is synchronised externally. The first edge after release loads normally.
- flush_e and stall_e asserted together: flush wins.
- Reset asserted mid-pipeline: all in-flight control is discarded.

Test Plan:
- Reset: rst_n=0 with op_d=LW and valid_d=1 → all *_e, *_m, *_w = 0 and illegal_cnt=0 with no clock edge. After release, LW reaches reg_write_w=1, result_src_w=01 at edge 3.
- Stream LW, SW, R, BEQ, I-ALU, JAL on consecutive cycles, no stall → each *_e bundle matches the table one cycle later. mem_write_m=1 exactly two cycles after SW. reg_write_w=0 three cycles after SW.
- Stall: LW, then stall_e=1 for 2 cycles while op_d=R → *_e holds the LW bundle for 3 cycles. EX/MEM sees LW once, then LW copies continue into MEM each cycle; the bench checks this matches the documented behaviour. R enters EX after stall drops.
- Flush: flush_e=1 with stall_e=1 and op_d=SW → next *_e is all zero, mem_write_m=0 one cycle later, illegal_cnt unchanged.
- EXT_OPS=0 vs 1 with op_d=LUI → EXT_OPS=1: result_src_e=11, imm_src_d=100, illegal_d=0. EXT_OPS=0: illegal_d=1, bubble in EX, illegal_cnt increments by 1.
- Saturation: CNT_W=2, op_d=7'b1111111, valid_d=1 for 6 cycles with one stall cycle mixed in → count goes 1, 2, 3, 3, stays 3. The stalled cycle adds nothing. valid_d=0 with the same opcode → no increment.

Source files
------------

// File: rtl/ctrl_pipe_decoder.sv
// Main decoder for the RISC-V pipeline: decodes the opcode in ID and carries the
// control bundle through ID/EX, EX/MEM and MEM/WB, with a saturating illegal-op counter.
module ctrl_pipe_decoder #(
    parameter int unsigned EXT_OPS = 1,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned FLUSH_M = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op_d,
    input  logic             valid_d,
    input  logic             stall_e,
    input  logic             flush_e,
    input  logic             flush_m,
    output logic [2:0]       imm_src_d,
    output logic             illegal_d,
    output logic             reg_write_e,
    output logic             mem_write_e,
    output logic             branch_e,
    output logic             jump_e,
    output logic             jalr_e,
    output logic             alu_src_e,
    output logic             alu_a_src_e,
    output logic [1:0]       result_src_e,
    output logic [1:0]       alu_op_e,
    output logic             reg_write_m,
    output logic             mem_write_m,
    output logic [1:0]       result_src_m,
    output logic             reg_write_w,
    output logic [1:0]       result_src_w,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef enum logic [6:0] {
        OP_LW    = 7'b0000011,
        OP_SW    = 7'b0100011,
        OP_R     = 7'b0110011,
        OP_BEQ   = 7'b1100011,
        OP_IALU  = 7'b0010011,
        OP_JAL   = 7'b1101111,
        OP_LUI   = 7'b0110111,
        OP_AUIPC = 7'b0010111,
        OP_JALR  = 7'b1100111
    } opcode_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       alu_src;
        logic       alu_a_src;
        logic [1:0] result_src;
        logic [1:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic [1:0] result_src;
    } mem_ctrl_t;

    ctrl_t     dec_d;
    ctrl_t     ctrl_e;
    mem_ctrl_t ctrl_m;
    logic      supported;
    logic      load_e;
    logic      flush_m_eff;

    always_comb begin
        dec_d     = '0;
        imm_src_d = '0;
        supported = 1'b0;
        case (op_d)
            OP_LW: begin
                supported         = 1'b1;
                dec_d.reg_write   = 1'b1;
                dec_d.alu_src     = 1'b1;
                dec_d.result_src  = 2'b01;
            end
            OP_SW: begin
                supported         = 1'b1;
                imm_src_d         = 3'b001;
                dec_d.alu_src     = 1'b1;
                dec_d.mem_write   = 1'b1;
            end
            OP_R: begin
                supported         = 1'b1;
                dec_d.reg_write   = 1'b1;
                dec_d.alu_op      = 2'b10;
            end
            OP_BEQ: begin
                supported         = 1'b1;
                imm_src_d         = 3'b010;
                dec_d.branch      = 1'b1;
                dec_d.alu_op      = 2'b01;
            end
            OP_IALU: begin
                supported         = 1'b1;
                dec_d.reg_write   = 1'b1;
                dec_d.alu_src     = 1'b1;
                dec_d.alu_op      = 2'b10;
            end
            OP_JAL: begin
                supported         = 1'b1;
                imm_src_d         = 3'b011;
                dec_d.reg_write   = 1'b1;
                dec_d.result_src  = 2'b10;
                dec_d.jump        = 1'b1;
            end
            OP_LUI: if (EXT_OPS != 0) begin
                supported         = 1'b1;
                imm_src_d         = 3'b100;
                dec_d.reg_write   = 1'b1;
                dec_d.alu_src     = 1'b1;
                dec_d.result_src  = 2'b11;
            end
            OP_AUIPC: if (EXT_OPS != 0) begin
                supported         = 1'b1;
                imm_src_d         = 3'b100;
                dec_d.reg_write   = 1'b1;
                dec_d.alu_src     = 1'b1;
                dec_d.alu_a_src   = 1'b1;
            end
            OP_JALR: if (EXT_OPS != 0) begin
                supported         = 1'b1;
                dec_d.reg_write   = 1'b1;
                dec_d.alu_src     = 1'b1;
                dec_d.result_src  = 2'b10;
                dec_d.jump        = 1'b1;
                dec_d.jalr        = 1'b1;
            end
            default: ;
        endcase
        // A non-valid slot decodes as a bubble whatever the opcode bits hold.
        if (!valid_d) begin
            dec_d     = '0;
            imm_src_d = '0;
        end
    end

    assign illegal_d   = valid_d & ~supported;
    assign load_e      = ~flush_e & ~stall_e;
    assign flush_m_eff = (FLUSH_M != 0) && flush_m;

    // The illegal tag is consumed at load time, so counting on load_e needs no stored tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_e      <= '0;
            illegal_cnt <= '0;
        end else begin
            if (flush_e) begin
                ctrl_e <= '0;
            end else if (!stall_e) begin
                ctrl_e <= dec_d;
            end
            if (load_e && illegal_d && (illegal_cnt != '1)) begin
                illegal_cnt <= illegal_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_m       <= '0;
            reg_write_w  <= 1'b0;
            result_src_w <= '0;
        end else begin
            if (flush_m_eff) begin
                ctrl_m <= '0;
            end else begin
                ctrl_m.reg_write  <= ctrl_e.reg_write;
                ctrl_m.mem_write  <= ctrl_e.mem_write;
                ctrl_m.result_src <= ctrl_e.result_src;
            end
            reg_write_w  <= ctrl_m.reg_write;
            result_src_w <= ctrl_m.result_src;
        end
    end

    assign reg_write_e  = ctrl_e.reg_write;
    assign mem_write_e  = ctrl_e.mem_write;
    assign branch_e     = ctrl_e.branch;
    assign jump_e       = ctrl_e.jump;
    assign jalr_e       = ctrl_e.jalr;
    assign alu_src_e    = ctrl_e.alu_src;
    assign alu_a_src_e  = ctrl_e.alu_a_src;
    assign result_src_e = ctrl_e.result_src;
    assign alu_op_e     = ctrl_e.alu_op;

    assign reg_write_m  = ctrl_m.reg_write;
    assign mem_write_m  = ctrl_m.mem_write;
    assign result_src_m = ctrl_m.result_src;

endmodule

// File: tb/tb_ctrl_pipe_decoder.sv
// Directed bench for ctrl_pipe_decoder: dut_a has the extended ops and EX/MEM flush,
// dut_b has neither and a 2-bit counter; both see the same stimulus.
module tb_ctrl_pipe_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op_d;
    logic       valid_d, stall_e, flush_e, flush_m;

    logic [2:0] imm_a, imm_b;
    logic       ill_a, ill_b;
    logic       rw_e_a, mw_e_a, br_e_a, j_e_a, jr_e_a, as_e_a, aas_e_a;
    logic       rw_e_b, mw_e_b, br_e_b, j_e_b, jr_e_b, as_e_b, aas_e_b;
    logic [1:0] rs_e_a, aop_e_a, rs_e_b, aop_e_b;
    logic       rw_m_a, mw_m_a, rw_m_b, mw_m_b;
    logic [1:0] rs_m_a, rs_m_b;
    logic       rw_w_a, rw_w_b;
    logic [1:0] rs_w_a, rs_w_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    logic [10:0] ex_a, ex_b;
    logic [3:0]  m_a, m_b;
    logic [2:0]  w_a, w_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ctrl_pipe_decoder #(.EXT_OPS(1), .CNT_W(8), .FLUSH_M(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .op_d(op_d), .valid_d(valid_d),
        .stall_e(stall_e), .flush_e(flush_e), .flush_m(flush_m),
        .imm_src_d(imm_a), .illegal_d(ill_a),
        .reg_write_e(rw_e_a), .mem_write_e(mw_e_a), .branch_e(br_e_a),
        .jump_e(j_e_a), .jalr_e(jr_e_a), .alu_src_e(as_e_a), .alu_a_src_e(aas_e_a),
        .result_src_e(rs_e_a), .alu_op_e(aop_e_a),
        .reg_write_m(rw_m_a), .mem_write_m(mw_m_a), .result_src_m(rs_m_a),
        .reg_write_w(rw_w_a), .result_src_w(rs_w_a), .illegal_cnt(cnt_a)
    );

    ctrl_pipe_decoder #(.EXT_OPS(0), .CNT_W(2), .FLUSH_M(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .op_d(op_d), .valid_d(valid_d),
        .stall_e(stall_e), .flush_e(flush_e), .flush_m(flush_m),
        .imm_src_d(imm_b), .illegal_d(ill_b),
        .reg_write_e(rw_e_b), .mem_write_e(mw_e_b), .branch_e(br_e_b),
        .jump_e(j_e_b), .jalr_e(jr_e_b), .alu_src_e(as_e_b), .alu_a_src_e(aas_e_b),
        .result_src_e(rs_e_b), .alu_op_e(aop_e_b),
        .reg_write_m(rw_m_b), .mem_write_m(mw_m_b), .result_src_m(rs_m_b),
        .reg_write_w(rw_w_b), .result_src_w(rs_w_b), .illegal_cnt(cnt_b)
    );

    // EX bundle layout: reg_write mem_write branch jump jalr alu_src alu_a_src result_src alu_op
    assign ex_a = {rw_e_a, mw_e_a, br_e_a, j_e_a, jr_e_a, as_e_a, aas_e_a, rs_e_a, aop_e_a};
    assign ex_b = {rw_e_b, mw_e_b, br_e_b, j_e_b, jr_e_b, as_e_b, aas_e_b, rs_e_b, aop_e_b};
    assign m_a  = {rw_m_a, mw_m_a, rs_m_a};
    assign m_b  = {rw_m_b, mw_m_b, rs_m_b};
    assign w_a  = {rw_w_a, rs_w_a};
    assign w_b  = {rw_w_b, rs_w_b};

    localparam logic [10:0] EX_LW    = 11'b10000100100;
    localparam logic [10:0] EX_SW    = 11'b01000100000;
    localparam logic [10:0] EX_R     = 11'b10000000010;
    localparam logic [10:0] EX_BEQ   = 11'b00100000001;
    localparam logic [10:0] EX_IALU  = 11'b10000100010;
    localparam logic [10:0] EX_JAL   = 11'b10010001000;
    localparam logic [10:0] EX_LUI   = 11'b10000101100;
    localparam logic [10:0] EX_AUIPC = 11'b10000110000;
    localparam logic [10:0] EX_JALR  = 11'b10011101000;

    typedef struct {
        logic [6:0]  op;
        logic        valid;
        logic        ext;
        logic [2:0]  imm;
        logic        ill;
        logic [10:0] ex;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(logic [6:0] op, logic valid, logic ext,
                                logic [2:0] imm, logic ill, logic [10:0] ex);
        vec_t v;
        v.op = op; v.valid = valid; v.ext = ext; v.imm = imm; v.ill = ill; v.ex = ex;
        return v;
    endfunction

    function automatic logic [3:0] m_of(logic [10:0] ex);
        return {ex[10], ex[9], ex[3:2]};
    endfunction

    function automatic logic [2:0] w_of(logic [10:0] ex);
        return {ex[10], ex[3:2]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic valid,
                         input logic stall, input logic flush, input logic fm);
        op_d = op; valid_d = valid; stall_e = stall; flush_e = flush; flush_m = fm;
    endtask

    initial begin
        logic [10:0] exp_b, prev1, prev2;
        logic        ill_exp_b;
        logic [2:0]  imm_exp_b;
        int          ecnt_a, ecnt_b;

        tbl[0]  = mk(7'b0000011, 1'b1, 1'b0, 3'b000, 1'b0, EX_LW);
        tbl[1]  = mk(7'b0100011, 1'b1, 1'b0, 3'b001, 1'b0, EX_SW);
        tbl[2]  = mk(7'b0110011, 1'b1, 1'b0, 3'b000, 1'b0, EX_R);
        tbl[3]  = mk(7'b1100011, 1'b1, 1'b0, 3'b010, 1'b0, EX_BEQ);
        tbl[4]  = mk(7'b0010011, 1'b1, 1'b0, 3'b000, 1'b0, EX_IALU);
        tbl[5]  = mk(7'b1101111, 1'b1, 1'b0, 3'b011, 1'b0, EX_JAL);
        tbl[6]  = mk(7'b0110111, 1'b1, 1'b1, 3'b100, 1'b0, EX_LUI);
        tbl[7]  = mk(7'b0010111, 1'b1, 1'b1, 3'b100, 1'b0, EX_AUIPC);
        tbl[8]  = mk(7'b1100111, 1'b1, 1'b1, 3'b000, 1'b0, EX_JALR);
        tbl[9]  = mk(7'b1111111, 1'b1, 1'b0, 3'b000, 1'b1, '0);
        tbl[10] = mk(7'b0000011, 1'b0, 1'b0, 3'b000, 1'b0, '0);
        tbl[11] = mk(7'b1111111, 1'b0, 1'b0, 3'b000, 1'b0, '0);
        tbl[12] = mk(7'b0000000, 1'b1, 1'b0, 3'b000, 1'b1, '0);

        // Reset state, observed before any clock edge
        rst_n = 1'b0;
        drive(7'b0000011, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("rst_ex_a", 32'(ex_a), 32'(0));
        check("rst_m_a", 32'(m_a), 32'(0));
        check("rst_w_a", 32'(w_a), 32'(0));
        check("rst_cnt_a", 32'(cnt_a), 32'(0));
        check("rst_ex_b", 32'(ex_b), 32'(0));
        check("rst_cnt_b", 32'(cnt_b), 32'(0));
        check("rst_imm_a", 32'(imm_a), 32'(0));
        check("rst_ill_a", 32'(ill_a), 32'(0));

        step();
        rst_n = 1'b1;

        // Streamed decode table; LW first, so it reaches WB on the third edge after release
        prev1 = '0; prev2 = '0; ecnt_a = 0; ecnt_b = 0;
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].op, tbl[i].valid, 1'b0, 1'b0, 1'b0);
            exp_b     = tbl[i].ext ? 11'b0 : tbl[i].ex;
            ill_exp_b = tbl[i].ext ? tbl[i].valid : tbl[i].ill;
            imm_exp_b = tbl[i].ext ? 3'b000 : tbl[i].imm;
            #1;
            check($sformatf("imm_a[%0d]", i), 32'(imm_a), 32'(tbl[i].imm));
            check($sformatf("ill_a[%0d]", i), 32'(ill_a), 32'(tbl[i].ill));
            check($sformatf("imm_b[%0d]", i), 32'(imm_b), 32'(imm_exp_b));
            check($sformatf("ill_b[%0d]", i), 32'(ill_b), 32'(ill_exp_b));
            step();
            if (tbl[i].ill) ecnt_a = (ecnt_a < 255) ? ecnt_a + 1 : 255;
            if (ill_exp_b)  ecnt_b = (ecnt_b < 3) ? ecnt_b + 1 : 3;
            check($sformatf("ex_a[%0d]", i), 32'(ex_a), 32'(tbl[i].ex));
            check($sformatf("ex_b[%0d]", i), 32'(ex_b), 32'(exp_b));
            check($sformatf("m_a[%0d]", i), 32'(m_a), 32'(m_of(prev1)));
            check($sformatf("w_a[%0d]", i), 32'(w_a), 32'(w_of(prev2)));
            check($sformatf("cnt_a[%0d]", i), 32'(cnt_a), 32'(ecnt_a));
            check($sformatf("cnt_b[%0d]", i), 32'(cnt_b), 32'(ecnt_b));
            prev2 = prev1;
            prev1 = tbl[i].ex;
        end

        // Stall: LW held in EX for three cycles, copies keep flowing into MEM
        drive(7'b0000011, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("stall_ex0", 32'(ex_a), 32'(EX_LW));
        drive(7'b0110011, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        check("stall_ex1", 32'(ex_a), 32'(EX_LW));
        check("stall_m1", 32'(m_a), 32'(m_of(EX_LW)));
        step();
        check("stall_ex2", 32'(ex_a), 32'(EX_LW));
        check("stall_m2", 32'(m_a), 32'(m_of(EX_LW)));
        check("stall_w2", 32'(w_a), 32'(w_of(EX_LW)));
        stall_e = 1'b0;
        step();
        check("stall_ex_r", 32'(ex_a), 32'(EX_R));
        check("stall_m3", 32'(m_a), 32'(m_of(EX_LW)));
        drive(7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("stall_m_r", 32'(m_a), 32'(m_of(EX_R)));
        check("stall_w_lw", 32'(w_a), 32'(w_of(EX_LW)));

        // Asynchronous reset mid-pipeline, between edges
        rst_n = 1'b0;
        #1;
        check("arst_m_a", 32'(m_a), 32'(0));
        check("arst_w_a", 32'(w_a), 32'(0));
        check("arst_cnt_a", 32'(cnt_a), 32'(0));
        check("arst_cnt_b", 32'(cnt_b), 32'(0));
        rst_n = 1'b1;

        // Flush beats stall; a flushed illegal op is not counted
        drive(7'b0000011, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("fl_ex_lw", 32'(ex_a), 32'(EX_LW));
        drive(7'b0100011, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        check("fl_ex_a", 32'(ex_a), 32'(0));
        check("fl_ex_b", 32'(ex_b), 32'(0));
        drive(7'b1111111, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        check("fl_m_mw", 32'(mw_m_a), 32'(0));
        check("fl_ex_ill", 32'(ex_a), 32'(0));
        check("fl_cnt_a", 32'(cnt_a), 32'(0));
        check("fl_cnt_b", 32'(cnt_b), 32'(0));

        // flush_m bubbles EX/MEM only where the path is enabled
        drive(7'b0100011, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("fm_ex_sw", 32'(ex_a), 32'(EX_SW));
        drive(7'b0000000, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check("fm_m_a", 32'(m_a), 32'(0));
        check("fm_m_b", 32'(m_b), 32'(m_of(EX_SW)));
        flush_m = 1'b0;
        step();
        check("fm_w_a", 32'(w_a), 32'(0));
        check("fm_w_b", 32'(w_b), 32'(w_of(EX_SW)));

        // Saturation of the 2-bit counter with a stall cycle mixed in
        drive(7'b1111111, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("sat_b1", 32'(cnt_b), 32'(1));
        check("sat_a1", 32'(cnt_a), 32'(1));
        step();
        check("sat_b2", 32'(cnt_b), 32'(2));
        stall_e = 1'b1;
        step();
        check("sat_b_stall", 32'(cnt_b), 32'(2));
        check("sat_a_stall", 32'(cnt_a), 32'(2));
        stall_e = 1'b0;
        step();
        check("sat_b3", 32'(cnt_b), 32'(3));
        step();
        check("sat_b4", 32'(cnt_b), 32'(3));
        step();
        check("sat_b5", 32'(cnt_b), 32'(3));
        check("sat_a5", 32'(cnt_a), 32'(5));
        check("sat_ex_b", 32'(ex_b), 32'(0));
        valid_d = 1'b0;
        #1;
        check("nv_ill_a", 32'(ill_a), 32'(0));
        step();
        check("nv_cnt_a", 32'(cnt_a), 32'(5));
        check("nv_cnt_b", 32'(cnt_b), 32'(3));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
